blink_timer: RTL and testbench

Sequenced blink generator for the DE0 7-segment "L" display path. It produces the registered `EN` level that drives the 7-segment L decoder directly downstream: `EN`=1 selects the "L" glyph, `EN`=0 selects the alternate glyph. Each blink is one ON phase followed by one OFF phase of equal, parameterised length. A burst runs for a programmed number of blinks, or continuously, under START/STOP pulse control.

---
 rtl/blink_timer.sv | 102 ++++++++++
 tb/tb_blink_timer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/blink_timer.sv
// Blink generator for the 7-segment "L" path: equal ON/OFF phases, counted or
// continuous bursts under START/STOP control, all outputs registered.
module blink_timer #(
   parameter int unsigned HALF_CYCLES = 25_000_000,
   parameter int unsigned CNT_W       = 25
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic       STOP,
   input  logic [3:0] COUNT,
   output logic       EN,
   output logic       BUSY,
   output logic       DONE
);

   typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_CYCLES - 1);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [3:0]       rem_q;
   logic             cont_q;
   logic             en_q, busy_q, done_q;

   wire last_w = (cnt_q == LAST);

   // Outputs are assigned alongside the state they decode, so they always
   // reflect the state being entered on this edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         cont_q  <= 1'b0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (START && !STOP) begin
                  state_q <= ON;
                  cnt_q   <= '0;
                  rem_q   <= COUNT;
                  cont_q  <= (COUNT == 4'd0);
                  en_q    <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            ON: begin
               if (STOP) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  en_q    <= 1'b0;
                  busy_q  <= 1'b0;
               end else if (last_w) begin
                  state_q <= OFF;
                  cnt_q   <= '0;
                  en_q    <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            OFF: begin
               if (STOP) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  en_q    <= 1'b0;
                  busy_q  <= 1'b0;
               end else if (last_w) begin
                  cnt_q <= '0;
                  if (cont_q || rem_q != 4'd1) begin
                     state_q <= ON;
                     en_q    <= 1'b1;
                     if (!cont_q) rem_q <= rem_q - 4'd1;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
               en_q    <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign EN   = en_q;
   assign BUSY = busy_q;
   assign DONE = done_q;

endmodule

// File: tb/tb_blink_timer.sv
// Scoreboard bench: the stimulus side queues hand-derived {EN,BUSY,DONE} per
// edge; a negedge monitor pops and compares against the selected instance.
module tb_blink_timer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start0 = 1'b0, stop0 = 1'b0, start1 = 1'b0, stop1 = 1'b0;
   logic [3:0] count0 = 4'd0, count1 = 4'd0;
   logic       en0, busy0, done0, en1, busy1, done1;

   always #5 clk = ~clk;

   blink_timer #(.HALF_CYCLES(4), .CNT_W(3)) dut0 (
      .CLK(clk), .RST(rst), .START(start0), .STOP(stop0), .COUNT(count0),
      .EN(en0), .BUSY(busy0), .DONE(done0));

   blink_timer #(.HALF_CYCLES(1), .CNT_W(2)) dut1 (
      .CLK(clk), .RST(rst), .START(start1), .STOP(stop1), .COUNT(count1),
      .EN(en1), .BUSY(busy1), .DONE(done1));

   typedef struct {
      bit       sel;
      bit [2:0] exp;
      string    name;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   bit   stim_done = 1'b0;

   // Monitor: one expectation per clock edge, checked mid-cycle.
   initial begin
      exp_t     e;
      bit [2:0] act;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e   = q.pop_front();
            act = e.sel ? {en1, busy1, done1} : {en0, busy0, done0};
            n_cmp++;
            if (act !== e.exp) begin
               n_err++;
               $display("FAIL %s: got EN/BUSY/DONE=%b, expected %b", e.name, act, e.exp);
            end
         end
      end
   end

   task automatic cyc(input bit sel, input bit st, input bit sp, input logic [3:0] cnt,
                      input bit r, input bit en, input bit bs, input bit dn, input string nm);
      exp_t e;
      if (sel) begin
         start1 = st; stop1 = sp; count1 = cnt; start0 = 1'b0; stop0 = 1'b0;
      end else begin
         start0 = st; stop0 = sp; count0 = cnt; start1 = 1'b0; stop1 = 1'b0;
      end
      rst = r;
      @(posedge clk);
      e.sel  = sel;
      e.exp  = {en, bs, dn};
      e.name = nm;
      q.push_back(e);
      #1;
   endtask

   // Counted burst: N blinks of H high then H low, DONE on the edge after.
   task automatic burst(input bit sel, input int h, input logic [3:0] n, input string nm);
      for (int b = 0; b < int'(n); b++)
         for (int i = 0; i < 2*h; i++)
            cyc(sel, (b == 0 && i == 0), 1'b0, n, 1'b0, (i < h), 1'b1, 1'b0, nm);
      cyc(sel, 1'b0, 1'b0, n, 1'b0, 1'b0, 1'b0, 1'b1, {nm, "_done"});
   endtask

   task automatic idle(input bit sel, input int k, input string nm);
      for (int i = 0; i < k; i++) cyc(sel, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, nm);
   endtask

   initial begin
      // 1. reset with START held high
      cyc(0, 1, 0, 4'd3, 1, 0, 0, 0, "rst_hold0");
      cyc(0, 1, 0, 4'd3, 1, 0, 0, 0, "rst_hold1");
      idle(0, 2, "rst_idle");
      idle(1, 1, "rst_idle_h1");

      // 2. counted burst of 3
      burst(0, 4, 4'd3, "burst3");
      idle(0, 3, "burst3_after");

      // 3. continuous, then STOP in the 2nd cycle of an ON phase
      for (int i = 0; i < 105; i++)
         cyc(0, (i == 0), 0, 4'd0, 0, ((i / 4) % 2 == 0), 1, 0, "cont");
      cyc(0, 0, 1, 4'd0, 0, 0, 0, 0, "cont_stop");
      idle(0, 3, "cont_after_stop");

      // 4a. START and STOP together in IDLE
      cyc(0, 1, 1, 4'd2, 0, 0, 0, 0, "start_stop_idle");
      idle(0, 2, "start_stop_after");

      // 4b. START with new COUNT during a COUNT=2 burst is ignored
      for (int i = 0; i < 16; i++)
         cyc(0, (i == 0 || i == 5 || i == 6), 0, (i < 5) ? 4'd2 : 4'd5, 0,
             ((i % 8) < 4), 1, 0, "restart_ign");
      cyc(0, 0, 0, 4'd5, 0, 0, 0, 1, "restart_ign_done");
      idle(0, 2, "restart_ign_after");

      // 5. reset during OFF phase of a COUNT=4 burst, then a single blink
      for (int i = 0; i < 5; i++)
         cyc(0, (i == 0), 0, 4'd4, 0, (i < 4), 1, 0, "pre_rst");
      cyc(0, 0, 0, 4'd4, 1, 0, 0, 0, "mid_rst");
      idle(0, 1, "mid_rst_after");
      burst(0, 4, 4'd1, "post_rst");
      idle(0, 2, "post_rst_after");

      // 6. minimum phase length
      burst(1, 1, 4'd2, "min_phase");
      idle(1, 2, "min_phase_after");
      // STOP mid-OFF on the single-cycle instance
      cyc(1, 1, 0, 4'd5, 0, 1, 1, 0, "min_stop_on");
      cyc(1, 0, 0, 4'd5, 0, 0, 1, 0, "min_stop_off");
      cyc(1, 0, 1, 4'd5, 0, 0, 0, 0, "min_stop");
      idle(1, 2, "min_stop_after");

      stim_done = 1'b1;
   end

   initial begin
      int budget = 2000;
      while (!(stim_done && q.size() == 0) && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      @(negedge clk);
      @(negedge clk);
      if (q.size() != 0 || !stim_done) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
